// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - glyph constants, digit indices and FSM encoding for seven_segment_decoder
package seven_seg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'b1111110;
  localparam logic [6:0] GLYPH_1 = 7'b0110000;
  localparam logic [6:0] GLYPH_2 = 7'b1101101;
  localparam logic [6:0] GLYPH_3 = 7'b1111001;
  localparam logic [6:0] GLYPH_4 = 7'b0110011;
  localparam logic [6:0] GLYPH_5 = 7'b1011011;
  localparam logic [6:0] GLYPH_6 = 7'b1011111;
  localparam logic [6:0] GLYPH_7 = 7'b1110000;
  localparam logic [6:0] GLYPH_8 = 7'b1111111;
  localparam logic [6:0] GLYPH_9 = 7'b1111011;

  localparam logic [6:0] SIGN_NEG = 7'b0000001;
  localparam logic [6:0] SIGN_POS = 7'b0000000;

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;
  localparam logic [1:0] DIG_SIGN = 2'd3;

  // HOLD: digit captured, waiting for the anode to move before re-arming
  typedef enum logic [2:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HOLD,
    ST_CONVERT,
    ST_REPORT
  } state_t;

  function automatic logic one_low(input logic [3:0] an);
    logic [3:0] l;
    l = ~an;
    return (l != 4'd0) && ((l & (l - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] an);
    if (!an[0])      return DIG_ONES;
    else if (!an[1]) return DIG_TENS;
    else if (!an[2]) return DIG_HUND;
    else             return DIG_SIGN;
  endfunction

endpackage

// File: rtl/seven_segment_glyph_decoder.sv
// rtl/seven_segment_glyph_decoder.sv - combinational segment pattern to BCD digit lookup
module seven_segment_glyph_decoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_glyph_ok
);

  always_comb begin
    o_bcd      = 4'd0;
    o_glyph_ok = 1'b1;
    case (i_seg)
      GLYPH_0: o_bcd = 4'd0;
      GLYPH_1: o_bcd = 4'd1;
      GLYPH_2: o_bcd = 4'd2;
      GLYPH_3: o_bcd = 4'd3;
      GLYPH_4: o_bcd = 4'd4;
      GLYPH_5: o_bcd = 4'd5;
      GLYPH_6: o_bcd = 4'd6;
      GLYPH_7: o_bcd = 4'd7;
      GLYPH_8: o_bcd = 4'd8;
      GLYPH_9: o_bcd = 4'd9;
      default: o_glyph_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - rebuilds a signed 8-bit value from a scanned 4-digit seven-segment bus
// Optional: SEVSEG_DEC_CHANGE_ONLY_EN suppresses data_valid when a frame repeats the held value.
module seven_segment_decoder
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              anode0_en,
  input  logic              anode1_en,
  input  logic              anode2_en,
  input  logic              anode3_en,
  input  logic              a_in,
  input  logic              b_in,
  input  logic              c_in,
  input  logic              d_in,
  input  logic              e_in,
  input  logic              f_in,
  input  logic              g_in,
  output logic signed [7:0] binary,
  output logic              data_valid,
  output logic              decode_error
);

`ifdef SEVSEG_DEC_CHANGE_ONLY_EN
  localparam bit CHANGE_ONLY = 1'b1;
`else
  localparam bit CHANGE_ONLY = 1'b0;
`endif
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_anode;
  logic [6:0]  r_seg;
  logic [CW-1:0] r_cnt;
  logic [3:0]  r_mask;
  logic        r_neg;
  logic [3:0]  r_hund, r_tens, r_ones;
  logic [9:0]  r_mag;
  logic [7:0]  r_binary;
  logic        r_data_valid, r_decode_error, r_glyph_err, r_first;

  logic [3:0]  w_anode;
  logic [6:0]  w_seg;
  logic        w_one_hot, w_same, w_arm, w_capture, w_cap_ok;
  logic [1:0]  w_digit;
  logic [3:0]  w_bcd, w_mask_nxt;
  logic        w_glyph_ok, w_sign_ok, w_range_ok;
  logic [7:0]  w_val;

  assign w_anode   = {anode3_en, anode2_en, anode1_en, anode0_en};
  assign w_seg     = {a_in, b_in, c_in, d_in, e_in, f_in, g_in};
  assign w_one_hot = one_low(w_anode);
  assign w_same    = (w_anode == r_anode) && (w_seg == r_seg);
  assign w_digit   = low_index(r_anode);
  assign w_sign_ok = (r_seg == SIGN_NEG) || (r_seg == SIGN_POS);
  assign w_cap_ok  = (w_digit == DIG_SIGN) ? w_sign_ok : w_glyph_ok;
  assign w_capture = (r_state == ST_SETTLE) && w_same && (r_cnt == CW'(SETTLE_CYCLES));
  assign w_mask_nxt = r_mask | (4'd1 << w_digit);
  assign w_arm = w_one_hot && ((r_state == ST_WAIT) ||
                               ((r_state == ST_SETTLE) && !w_same) ||
                               ((r_state == ST_HOLD) && (w_anode != r_anode)));

  assign w_range_ok = r_neg ? (r_mag <= 10'd128) : (r_mag <= 10'd127);
  assign w_val      = r_neg ? (8'd0 - r_mag[7:0]) : r_mag[7:0];

  assign binary       = r_binary;
  assign data_valid   = r_data_valid;
  assign decode_error = r_decode_error;

  seven_segment_glyph_decoder u_glyph (
    .i_seg      (r_seg),
    .o_bcd      (w_bcd),
    .o_glyph_ok (w_glyph_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_WAIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT:   if (w_one_hot) w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!w_same)
          w_state_nxt = w_one_hot ? ST_SETTLE : ST_WAIT;
        else if (w_capture)
          w_state_nxt = (w_cap_ok && (w_mask_nxt == 4'b1111)) ? ST_CONVERT : ST_HOLD;
      end
      ST_HOLD:   if (w_anode != r_anode) w_state_nxt = w_one_hot ? ST_SETTLE : ST_WAIT;
      ST_CONVERT: w_state_nxt = ST_REPORT;
      ST_REPORT:  w_state_nxt = ST_HOLD;
      default:    w_state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_anode        <= 4'hF;
      r_seg          <= 7'd0;
      r_cnt          <= '0;
      r_mask         <= 4'd0;
      r_neg          <= 1'b0;
      r_hund         <= 4'd0;
      r_tens         <= 4'd0;
      r_ones         <= 4'd0;
      r_mag          <= 10'd0;
      r_binary       <= 8'd0;
      r_data_valid   <= 1'b0;
      r_decode_error <= 1'b0;
      r_glyph_err    <= 1'b0;
      r_first        <= 1'b1;
    end else begin
      r_data_valid   <= 1'b0;
      r_decode_error <= r_glyph_err;
      r_glyph_err    <= 1'b0;

      if (w_arm) begin
        r_anode <= w_anode;
        r_seg   <= w_seg;
        r_cnt   <= CW'(1);
      end else if ((r_state == ST_SETTLE) && w_same && (r_cnt != CW'(SETTLE_CYCLES))) begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_capture) begin
        if (!w_cap_ok) begin
          r_glyph_err <= 1'b1;
          r_mask      <= 4'd0;
        end else begin
          r_mask <= w_mask_nxt;
          case (w_digit)
            DIG_ONES: r_ones <= w_bcd;
            DIG_TENS: r_tens <= w_bcd;
            DIG_HUND: r_hund <= w_bcd;
            default:  r_neg  <= (r_seg == SIGN_NEG);
          endcase
        end
      end

      if (r_state == ST_CONVERT)
        r_mag <= 10'(r_hund) * 10'd100 + 10'(r_tens) * 10'd10 + 10'(r_ones);

      if (r_state == ST_REPORT) begin
        r_mask <= 4'd0;
        if (w_range_ok) begin
          r_binary <= w_val;
          r_first  <= 1'b0;
          if (!CHANGE_ONLY || r_first || (w_val != r_binary))
            r_data_valid <= 1'b1;
        end else begin
          r_decode_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb/tb_seven_segment_decoder.sv - self-checking bench for seven_segment_decoder (honours SEVSEG_DEC_CHANGE_ONLY_EN)
module tb_seven_segment_decoder;

  localparam int SC = 4;
`ifdef SEVSEG_DEC_CHANGE_ONLY_EN
  localparam bit CO = 1'b1;
`else
  localparam bit CO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic an0, an1, an2, an3;
  logic sa, sb, sc, sd, se, sf, sg;
  logic [7:0] dut_bin;
  logic dut_dv, dut_err;

  seven_segment_decoder #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst),
    .anode0_en(an0), .anode1_en(an1), .anode2_en(an2), .anode3_en(an3),
    .a_in(sa), .b_in(sb), .c_in(sc), .d_in(sd), .e_in(se), .f_in(sf), .g_in(sg),
    .binary(dut_bin), .data_valid(dut_dv), .decode_error(dut_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, n_dv = 0, n_err = 0, last_evt = -100, dig_start = 0;
  logic [6:0] glyph [10];
  logic [7:0] m_held = 8'd0;
  bit m_first = 1'b1;

  typedef struct {
    logic [6:0] s, h, t, o;
    bit         valid;
    logic [7:0] bin;
    int         lat;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (dut_dv)  begin n_dv++;  last_evt = cyc; end
    if (dut_err) begin n_err++; last_evt = cyc; end
  endtask

  task automatic set_bus(input logic [3:0] an, input logic [6:0] s);
    {an3, an2, an1, an0} = an;
    {sa, sb, sc, sd, se, sf, sg} = s;
  endtask

  task automatic show(input int idx, input logic [6:0] s, input int dwell);
    logic [3:0] an;
    an = 4'hF;
    an[idx] = 1'b0;
    set_bus(an, s);
    dig_start = cyc;
    repeat (dwell) tick();
  endtask

  task automatic idle(input int n);
    set_bus(4'hF, 7'd0);
    repeat (n) tick();
  endtask

  function automatic bit is_glyph(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (glyph[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  // expected pulses for a frame under the spec's rules; updates the held-value model
  task automatic expect_frame(input bit ok, input logic [7:0] v, output int e_dv, output int e_err);
    e_dv = 0;
    e_err = 0;
    if (!ok) e_err = 1;
    else begin
      if (!CO || m_first || v != m_held) e_dv = 1;
      m_held = v;
      m_first = 1'b0;
    end
  endtask

  initial begin
    int dv0, er0, e_dv, e_err, ones_start;
    glyph[0] = 7'b1111110; glyph[1] = 7'b0110000; glyph[2] = 7'b1101101;
    glyph[3] = 7'b1111001; glyph[4] = 7'b0110011; glyph[5] = 7'b1011011;
    glyph[6] = 7'b1011111; glyph[7] = 7'b1110000; glyph[8] = 7'b1111111;
    glyph[9] = 7'b1111011;

    tbl[0] = '{7'b0000000, glyph[0], glyph[4], glyph[2], 1'b1, 8'd42,  2};
    tbl[1] = '{7'b0000001, glyph[1], glyph[2], glyph[8], 1'b1, 8'h80,  2};
    tbl[2] = '{7'b0000001, glyph[1], glyph[2], glyph[9], 1'b0, 8'h80,  2};
    tbl[3] = '{7'b0000000, glyph[2], glyph[0], glyph[0], 1'b0, 8'h80,  2};
    tbl[4] = '{7'b0000000, glyph[0], glyph[0], 7'b1000000, 1'b0, 8'h80, 1};
    tbl[5] = '{7'b0000000, glyph[0], glyph[0], glyph[7], 1'b1, 8'd7,   2};
    tbl[6] = '{7'b0000001, glyph[0], glyph[0], glyph[0], 1'b1, 8'd0,   2};
    tbl[7] = '{7'b0000000, glyph[1], glyph[2], glyph[7], 1'b1, 8'd127, 2};

    set_bus(4'hF, 7'd0);
    tick(); tick();
    check("reset_binary", 32'(dut_bin), 32'd0);
    check("reset_valid", 32'(dut_dv), 32'd0);
    check("reset_error", 32'(dut_err), 32'd0);
    rst = 1'b0;
    idle(3);

    for (int i = 0; i < 8; i++) begin
      dv0 = n_dv; er0 = n_err;
      show(3, tbl[i].s, 8); show(2, tbl[i].h, 8); show(1, tbl[i].t, 8);
      show(0, tbl[i].o, 8);
      ones_start = dig_start;
      idle(5);
      expect_frame(tbl[i].valid, tbl[i].bin, e_dv, e_err);
      check($sformatf("tbl%0d_valid_count", i), 32'(n_dv - dv0), 32'(e_dv));
      check($sformatf("tbl%0d_error_count", i), 32'(n_err - er0), 32'(e_err));
      check($sformatf("tbl%0d_binary", i), 32'(dut_bin), 32'(m_held));
      if (e_dv + e_err > 0)
        check($sformatf("tbl%0d_latency", i), 32'(last_evt - (ones_start + SC + 1)), 32'(tbl[i].lat));
    end

    // short dwells never settle
    dv0 = n_dv; er0 = n_err;
    for (int r = 0; r < 2; r++) begin
      show(3, 7'b0000001, SC - 1); show(2, glyph[0], SC - 1);
      show(1, glyph[0], SC - 1);   show(0, glyph[9], SC - 1);
    end
    idle(5);
    check("short_dwell_valid", 32'(n_dv - dv0), 32'd0);
    check("short_dwell_error", 32'(n_err - er0), 32'd0);
    // two anodes low at once never capture
    set_bus(4'b0011, 7'b0000001); repeat (8) tick();
    set_bus(4'b1100, glyph[3]);   repeat (8) tick();
    set_bus(4'b0101, glyph[3]);   repeat (8) tick();
    set_bus(4'b1010, glyph[3]);   repeat (8) tick();
    idle(5);
    check("multi_anode_valid", 32'(n_dv - dv0), 32'd0);
    check("multi_anode_error", 32'(n_err - er0), 32'd0);
    check("multi_anode_binary", 32'(dut_bin), 32'(m_held));

    // reset mid-frame
    show(2, glyph[0], 8); show(1, glyph[0], 8); show(0, glyph[5], 8);
    rst = 1'b1;
    #1;
    check("async_reset_binary", 32'(dut_bin), 32'd0);
    check("async_reset_valid", 32'(dut_dv), 32'd0);
    tick(); tick();
    rst = 1'b0;
    m_held = 8'd0; m_first = 1'b1;
    dv0 = n_dv; er0 = n_err;
    show(3, 7'b0000000, 8);
    idle(5);
    check("post_reset_partial_valid", 32'(n_dv - dv0), 32'd0);
    check("post_reset_partial_binary", 32'(dut_bin), 32'd0);
    show(2, glyph[0], 8); show(1, glyph[0], 8); show(0, glyph[5], 8);
    idle(5);
    expect_frame(1'b1, 8'd5, e_dv, e_err);
    check("plus5_valid", 32'(n_dv - dv0), 32'(e_dv));
    check("plus5_binary", 32'(dut_bin), 32'd5);
    dv0 = n_dv;
    show(3, 7'b0000000, 8); show(2, glyph[0], 8); show(1, glyph[0], 8); show(0, glyph[5], 8);
    idle(5);
    expect_frame(1'b1, 8'd5, e_dv, e_err);
    check("plus5_repeat_valid", 32'(n_dv - dv0), 32'(e_dv));
    check("plus5_repeat_total", 32'(n_dv - dv0 + 1), CO ? 32'd1 : 32'd2);
    check("plus5_repeat_binary", 32'(dut_bin), 32'd5);

    // random frames, random digit order and dwell, occasional bad glyph on the last digit
    for (int f = 0; f < 30; f++) begin
      int ord [4];
      logic [6:0] segs [4];
      int h, t, o, mag, last, k, tmp;
      bit neg, bad, ok;
      logic [7:0] v;
      logic [6:0] p;
      for (int i = 0; i < 4; i++) ord[i] = i;
      for (int i = 3; i > 0; i--) begin
        k = $urandom_range(0, i);
        tmp = ord[i]; ord[i] = ord[k]; ord[k] = tmp;
      end
      neg = $urandom_range(0, 1);
      h = $urandom_range(0, 2); t = $urandom_range(0, 9); o = $urandom_range(0, 9);
      mag = 100 * h + 10 * t + o;
      segs[3] = neg ? 7'b0000001 : 7'b0000000;
      segs[2] = glyph[h]; segs[1] = glyph[t]; segs[0] = glyph[o];
      last = ord[3];
      bad = ($urandom_range(0, 5) == 0);
      if (bad) begin
        p = 7'(($urandom_range(2, 127)));
        if (last != 3)
          for (int n = 0; n < 20 && is_glyph(p); n++) p = 7'($urandom_range(0, 127));
        if (last != 3 && is_glyph(p)) p = 7'b1000000;
        segs[last] = p;
      end
      ok = !bad && (neg ? (mag <= 128) : (mag <= 127));
      v = neg ? 8'(-mag) : 8'(mag);
      dv0 = n_dv; er0 = n_err;
      for (int i = 0; i < 4; i++) show(ord[i], segs[ord[i]], $urandom_range(SC + 1, SC + 6));
      ones_start = dig_start;
      idle(5);
      expect_frame(ok, v, e_dv, e_err);
      check($sformatf("rnd%0d_valid_count", f), 32'(n_dv - dv0), 32'(e_dv));
      check($sformatf("rnd%0d_error_count", f), 32'(n_err - er0), 32'(e_err));
      check($sformatf("rnd%0d_binary", f), 32'(dut_bin), 32'(m_held));
      if (e_dv + e_err > 0)
        check($sformatf("rnd%0d_latency", f), 32'(last_evt - (ones_start + SC + 1)), bad ? 32'd1 : 32'd2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
